// File: rtl/ecc_secded_pipe.sv
// ecc_secded_pipe: parametrised SECDED encoder/decoder with injection, 2-stage decode pipe, counters and error log
module ecc_secded_pipe #(
  parameter int DATA_WIDTH = 75,
  parameter int CNT_WIDTH = 16,
  localparam int PARITY_WIDTH = $clog2(DATA_WIDTH + $clog2(DATA_WIDTH + 1) + 1) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enc_valid,
  input  logic [DATA_WIDTH-1:0]   enc_data,
  input  logic                    enc_inj_en,
  input  logic                    enc_inj_dbl,
  input  logic [7:0]              enc_inj_pos0,
  input  logic [7:0]              enc_inj_pos1,
  output logic                    enc_out_valid,
  output logic [DATA_WIDTH-1:0]   enc_out_data,
  output logic [PARITY_WIDTH-1:0] enc_out_parity,
  input  logic                    dec_in_valid,
  output logic                    dec_in_ready,
  input  logic [DATA_WIDTH-1:0]   dec_in_data,
  input  logic [PARITY_WIDTH-1:0] dec_in_parity,
  output logic                    dec_out_valid,
  input  logic                    dec_out_ready,
  output logic [DATA_WIDTH-1:0]   dec_out_data,
  output logic                    dec_out_sbit,
  output logic                    dec_out_dbit,
  output logic [PARITY_WIDTH-1:0] dec_out_syndrome,
  input  logic                    bypass,
  input  logic                    cnt_clr,
  output logic [CNT_WIDTH-1:0]    sbit_cnt,
  output logic [CNT_WIDTH-1:0]    dbit_cnt,
  output logic                    err_log_valid,
  output logic [PARITY_WIDTH-1:0] err_log_syndrome
);
  localparam int DW = DATA_WIDTH;
  localparam int PW = PARITY_WIDTH;
  localparam int R = PW - 1;

  // Hamming position of the last data bit; syndromes above it name no real bit
  function automatic int last_pos(input int n);
    int p;
    p = 2;
    for (int i = 0; i < n; i++) begin
      p++;
      if ((p & (p - 1)) == 0) p++;
    end
    return p;
  endfunction

  localparam int HI = last_pos(DW);
  localparam logic [R-1:0] HI_S = R'(HI);

  // Hamming check bits: data bit i sits at the i-th non-power-of-two position from 3
  function automatic logic [R-1:0] ham(input logic [DW-1:0] d);
    logic [R-1:0] h;
    int p;
    h = '0;
    p = 2;
    for (int i = 0; i < DW; i++) begin
      p++;
      if ((p & (p - 1)) == 0) p++;
      for (int k = 0; k < R; k++) h[k] = h[k] ^ (d[i] & p[k]);
    end
    return h;
  endfunction

  // One-hot over data bits whose position equals the syndrome (zero for parity/out-of-range positions)
  function automatic logic [DW-1:0] fix_mask(input logic [R-1:0] s);
    logic [DW-1:0] m;
    int p;
    m = '0;
    p = 2;
    for (int i = 0; i < DW; i++) begin
      p++;
      if ((p & (p - 1)) == 0) p++;
      m[i] = (p[R-1:0] == s);
    end
    return m;
  endfunction

  logic                 enc_valid_q;
  logic [DW-1:0]        enc_data_q;
  logic [PW-1:0]        enc_par_q;
  logic [DW-1:0]        inj;
  logic [R-1:0]         enc_h;
  logic [R-1:0]         dec_h;
  logic                 s1_valid_q;
  logic [DW-1:0]        s1_data_q;
  logic [PW-1:0]        s1_syn_q;
  logic [PW-1:0]        syn_d;
  logic                 s2_valid_q;
  logic [DW-1:0]        s2_data_q;
  logic                 s2_sbit_q;
  logic                 s2_dbit_q;
  logic [PW-1:0]        s2_syn_q;
  logic [DW-1:0]        data_d;
  logic                 sbit_d;
  logic                 dbit_d;
  logic                 s1_adv;
  logic                 s2_adv;
  logic                 xfer;
  logic [CNT_WIDTH-1:0] sbit_cnt_q;
  logic [CNT_WIDTH-1:0] dbit_cnt_q;
  logic                 log_valid_q;
  logic [PW-1:0]        log_syn_q;

  // Injection pattern, check bits and decode syndrome/correction
  always_comb begin
    inj = enc_inj_en ? ((DW'(1) << enc_inj_pos0) ^ (enc_inj_dbl ? (DW'(1) << enc_inj_pos1) : '0)) : '0;
    enc_h = ham(enc_data);
    dec_h = ham(dec_in_data);
    syn_d = {^{dec_in_data, dec_in_parity}, dec_in_parity[R-1:0] ^ dec_h};
    sbit_d = !bypass && s1_syn_q[R] && (s1_syn_q[R-1:0] <= HI_S);
    dbit_d = !bypass && (s1_syn_q[R] ? (s1_syn_q[R-1:0] > HI_S) : (s1_syn_q[R-1:0] != '0));
    data_d = (bypass || !s1_syn_q[R]) ? s1_data_q : s1_data_q ^ fix_mask(s1_syn_q[R-1:0]);
    s2_adv = !s2_valid_q || dec_out_ready;
    s1_adv = !s1_valid_q || s2_adv;
    xfer = s2_valid_q && dec_out_ready;
  end

  // Registered encoder; parity covers the payload before injection
  always_ff @(posedge clk) begin
    if (rst) begin
      enc_valid_q <= 1'b0;
      enc_data_q <= '0;
      enc_par_q <= '0;
    end else begin
      enc_valid_q <= enc_valid;
      if (enc_valid) begin
        enc_data_q <= enc_data ^ inj;
        enc_par_q <= {^enc_data ^ ^enc_h, enc_h};
      end
    end
  end

  // Two-stage decode pipeline with valid/ready advance
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q <= '0;
      s1_syn_q <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q <= '0;
      s2_sbit_q <= 1'b0;
      s2_dbit_q <= 1'b0;
      s2_syn_q <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= dec_in_valid;
        if (dec_in_valid) begin
          s1_data_q <= dec_in_data;
          s1_syn_q <= syn_d;
        end
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= data_d;
          s2_sbit_q <= sbit_d;
          s2_dbit_q <= dbit_d;
          s2_syn_q <= s1_syn_q;
        end
      end
    end
  end

  // Saturating error counters and sticky first-error log; clear wins
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      sbit_cnt_q <= '0;
      dbit_cnt_q <= '0;
      log_valid_q <= 1'b0;
      log_syn_q <= '0;
    end else if (xfer) begin
      if (s2_sbit_q && !(&sbit_cnt_q)) sbit_cnt_q <= sbit_cnt_q + 1'b1;
      if (s2_dbit_q && !(&dbit_cnt_q)) dbit_cnt_q <= dbit_cnt_q + 1'b1;
      if ((s2_sbit_q || s2_dbit_q) && !log_valid_q) begin
        log_valid_q <= 1'b1;
        log_syn_q <= s2_syn_q;
      end
    end
  end

  assign enc_out_valid = enc_valid_q;
  assign enc_out_data = enc_data_q;
  assign enc_out_parity = enc_par_q;
  assign dec_in_ready = s1_adv;
  assign dec_out_valid = s2_valid_q;
  assign dec_out_data = s2_data_q;
  assign dec_out_sbit = s2_sbit_q;
  assign dec_out_dbit = s2_dbit_q;
  assign dec_out_syndrome = s2_syn_q;
  assign sbit_cnt = sbit_cnt_q;
  assign dbit_cnt = dbit_cnt_q;
  assign err_log_valid = log_valid_q;
  assign err_log_syndrome = log_syn_q;
endmodule

// File: tb/tb_ecc_secded_pipe.sv
// tb_ecc_secded_pipe: directed self-checking bench for ecc_secded_pipe (DATA_WIDTH=75, CNT_WIDTH=4)
module tb_ecc_secded_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        enc_valid;
  logic [74:0] enc_data;
  logic        enc_inj_en;
  logic        enc_inj_dbl;
  logic [7:0]  enc_inj_pos0;
  logic [7:0]  enc_inj_pos1;
  logic        enc_out_valid;
  logic [74:0] enc_out_data;
  logic [7:0]  enc_out_parity;
  logic        dec_in_valid;
  logic        dec_in_ready;
  logic [74:0] dec_in_data;
  logic [7:0]  dec_in_parity;
  logic        dec_out_valid;
  logic        dec_out_ready;
  logic [74:0] dec_out_data;
  logic        dec_out_sbit;
  logic        dec_out_dbit;
  logic [7:0]  dec_out_syndrome;
  logic        bypass;
  logic        cnt_clr;
  logic [3:0]  sbit_cnt;
  logic [3:0]  dbit_cnt;
  logic        err_log_valid;
  logic [7:0]  err_log_syndrome;
  int n_cmp = 0;
  int n_fail = 0;

  ecc_secded_pipe #(.DATA_WIDTH(75), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .enc_valid(enc_valid), .enc_data(enc_data), .enc_inj_en(enc_inj_en), .enc_inj_dbl(enc_inj_dbl),
    .enc_inj_pos0(enc_inj_pos0), .enc_inj_pos1(enc_inj_pos1),
    .enc_out_valid(enc_out_valid), .enc_out_data(enc_out_data), .enc_out_parity(enc_out_parity),
    .dec_in_valid(dec_in_valid), .dec_in_ready(dec_in_ready), .dec_in_data(dec_in_data),
    .dec_in_parity(dec_in_parity), .dec_out_valid(dec_out_valid), .dec_out_ready(dec_out_ready),
    .dec_out_data(dec_out_data), .dec_out_sbit(dec_out_sbit), .dec_out_dbit(dec_out_dbit),
    .dec_out_syndrome(dec_out_syndrome), .bypass(bypass), .cnt_clr(cnt_clr),
    .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .err_log_valid(err_log_valid),
    .err_log_syndrome(err_log_syndrome)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [74:0] d, input logic [7:0] p);
    dec_in_valid = 1'b1;
    dec_in_data = d;
    dec_in_parity = p;
    tick();
    dec_in_valid = 1'b0;
    tick();
  endtask

  task automatic chk_out(input string tag, input logic [74:0] d, input logic [7:0] syn, input logic sb, input logic db);
    chk({tag, "_valid"}, 128'(dec_out_valid), 128'(1'b1));
    chk({tag, "_data"}, 128'(dec_out_data), 128'(d));
    chk({tag, "_syn"}, 128'(dec_out_syndrome), 128'(syn));
    chk({tag, "_sbit"}, 128'(dec_out_sbit), 128'(sb));
    chk({tag, "_dbit"}, 128'(dec_out_dbit), 128'(db));
  endtask

  task automatic chk_cnt(input string tag, input logic [3:0] sc, input logic [3:0] dc, input logic lv, input logic [7:0] ls);
    chk({tag, "_sbit_cnt"}, 128'(sbit_cnt), 128'(sc));
    chk({tag, "_dbit_cnt"}, 128'(dbit_cnt), 128'(dc));
    chk({tag, "_log_valid"}, 128'(err_log_valid), 128'(lv));
    chk({tag, "_log_syn"}, 128'(err_log_syndrome), 128'(ls));
  endtask

  initial begin
    rst = 1'b1;
    enc_valid = 1'b0;
    enc_data = '0;
    enc_inj_en = 1'b0;
    enc_inj_dbl = 1'b0;
    enc_inj_pos0 = 8'd0;
    enc_inj_pos1 = 8'd0;
    dec_in_valid = 1'b0;
    dec_in_data = '0;
    dec_in_parity = '0;
    dec_out_ready = 1'b1;
    bypass = 1'b0;
    cnt_clr = 1'b0;
    tick();
    tick();
    chk("rst_enc_valid", 128'(enc_out_valid), 128'(1'b0));
    chk("rst_enc_data", 128'(enc_out_data), 128'(0));
    chk("rst_enc_par", 128'(enc_out_parity), 128'(0));
    chk("rst_dec_valid", 128'(dec_out_valid), 128'(1'b0));
    chk("rst_dec_ready", 128'(dec_in_ready), 128'(1'b1));
    chk_cnt("rst", 4'd0, 4'd0, 1'b0, 8'h00);
    rst = 1'b0;

    enc_valid = 1'b1;
    enc_data = '0;
    tick();
    chk("enc0_valid", 128'(enc_out_valid), 128'(1'b1));
    chk("enc0_par", 128'(enc_out_parity), 128'h00);
    chk("enc0_data", 128'(enc_out_data), 128'h0);
    enc_data = 75'd8;
    tick();
    chk("enc8_par", 128'(enc_out_parity), 128'h07);
    enc_data = 75'd3;
    tick();
    chk("enc3_par", 128'(enc_out_parity), 128'h06);
    enc_data = 75'd0;
    enc_inj_en = 1'b1;
    enc_inj_pos0 = 8'd0;
    tick();
    chk("inj1_data", 128'(enc_out_data), 128'h1);
    chk("inj1_par", 128'(enc_out_parity), 128'h00);
    enc_inj_pos0 = 8'd80;
    tick();
    chk("inj_oob_data", 128'(enc_out_data), 128'h0);
    enc_inj_dbl = 1'b1;
    enc_inj_pos0 = 8'd5;
    enc_inj_pos1 = 8'd5;
    tick();
    chk("inj_cancel_data", 128'(enc_out_data), 128'h0);
    enc_inj_pos0 = 8'd0;
    enc_inj_pos1 = 8'd1;
    tick();
    chk("inj2_data", 128'(enc_out_data), 128'h3);
    chk("inj2_par", 128'(enc_out_parity), 128'h00);
    enc_valid = 1'b0;
    enc_inj_en = 1'b0;
    enc_inj_dbl = 1'b0;
    tick();
    chk("enc_idle_valid", 128'(enc_out_valid), 128'(1'b0));

    dec_in_valid = 1'b1;
    dec_in_data = '0;
    dec_in_parity = '0;
    tick();
    dec_in_valid = 1'b0;
    chk("lat1_valid", 128'(dec_out_valid), 128'(1'b0));
    tick();
    chk_out("clean", 75'd0, 8'h00, 1'b0, 1'b0);
    tick();
    chk_cnt("clean", 4'd0, 4'd0, 1'b0, 8'h00);

    send(75'd1, 8'h00);
    chk_out("sfix", 75'd0, 8'b1000_0011, 1'b1, 1'b0);
    tick();
    chk_cnt("sfix", 4'd1, 4'd0, 1'b1, 8'h83);
    send(75'd0, 8'h04);
    chk_out("spar", 75'd0, 8'b1000_0100, 1'b1, 1'b0);
    tick();
    chk_cnt("spar", 4'd2, 4'd0, 1'b1, 8'h83);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk_cnt("clr", 4'd0, 4'd0, 1'b0, 8'h00);

    send(75'd3, 8'h00);
    chk_out("dbl", 75'd3, 8'b0000_0110, 1'b0, 1'b1);
    tick();
    chk_cnt("dbl", 4'd0, 4'd1, 1'b1, 8'h06);
    send({1'b1, 74'd0}, 8'h00);
    chk_out("top_bit", 75'd0, 8'hD2, 1'b1, 1'b0);
    tick();
    send(75'd0, 8'h7F);
    chk_out("oor", 75'd0, 8'hFF, 1'b0, 1'b1);
    tick();
    chk_cnt("oor", 4'd1, 4'd2, 1'b1, 8'h06);
    send(75'd0, 8'h80);
    chk_out("ovr_par", 75'd0, 8'h80, 1'b1, 1'b0);
    tick();

    dec_out_ready = 1'b0;
    dec_in_valid = 1'b1;
    dec_in_data = 75'd1;
    dec_in_parity = 8'h83;
    chk("bp_rdy_a", 128'(dec_in_ready), 128'(1'b1));
    tick();
    dec_in_data = 75'd2;
    dec_in_parity = 8'h85;
    chk("bp_rdy_b", 128'(dec_in_ready), 128'(1'b1));
    tick();
    dec_in_data = 75'd8;
    dec_in_parity = 8'h07;
    chk("bp_rdy_c", 128'(dec_in_ready), 128'(1'b0));
    chk_out("bp_hold0", 75'd1, 8'h00, 1'b0, 1'b0);
    tick();
    chk_out("bp_hold1", 75'd1, 8'h00, 1'b0, 1'b0);
    chk("bp_rdy_hold", 128'(dec_in_ready), 128'(1'b0));
    dec_out_ready = 1'b1;
    #1;
    chk("bp_rdy_rel", 128'(dec_in_ready), 128'(1'b1));
    tick();
    dec_in_valid = 1'b0;
    chk_out("bp_out_b", 75'd2, 8'h00, 1'b0, 1'b0);
    tick();
    chk_out("bp_out_c", 75'd8, 8'h00, 1'b0, 1'b0);
    tick();
    chk("bp_drain", 128'(dec_out_valid), 128'(1'b0));
    chk_cnt("bp", 4'd2, 4'd2, 1'b1, 8'h06);

    dec_in_valid = 1'b1;
    dec_in_data = 75'd1;
    dec_in_parity = 8'h00;
    repeat (20) tick();
    dec_in_valid = 1'b0;
    repeat (3) tick();
    chk_cnt("sat", 4'd15, 4'd2, 1'b1, 8'h06);
    send(75'd1, 8'h00);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk_cnt("clr_xfer", 4'd0, 4'd0, 1'b0, 8'h00);

    bypass = 1'b1;
    send(75'd1, 8'h00);
    chk_out("byp", 75'd1, 8'b1000_0011, 1'b0, 1'b0);
    tick();
    chk_cnt("byp", 4'd0, 4'd0, 1'b0, 8'h00);
    bypass = 1'b0;

    dec_in_valid = 1'b1;
    dec_in_data = 75'd1;
    dec_in_parity = 8'h83;
    tick();
    dec_in_data = 75'd2;
    dec_in_parity = 8'h85;
    tick();
    chk("flight_valid", 128'(dec_out_valid), 128'(1'b1));
    rst = 1'b1;
    dec_in_valid = 1'b0;
    tick();
    chk("rstf_valid", 128'(dec_out_valid), 128'(1'b0));
    chk("rstf_data", 128'(dec_out_data), 128'(0));
    chk("rstf_ready", 128'(dec_in_ready), 128'(1'b1));
    rst = 1'b0;
    tick();
    chk("rstf_after", 128'(dec_out_valid), 128'(1'b0));
    tick();
    chk("rstf_after2", 128'(dec_out_valid), 128'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ecc_secded_pipe.md
Name: ecc_secded_pipe

Overview:
Parametrised, pipelined SECDED (Hamming plus overall parity) encoder/decoder for FIFO and RAM payload protection in the sync_aggr datapath.
- Replaces the fixed 75-bit combinational calculator.
- DATA_WIDTH is generic and parity width is derived.
- Adds a registered encode path with error injection, a 2-stage valid/ready decode pipeline, saturating error counters and a sticky first-error syndrome log.

Parameters:
DATA_WIDTH, 75, payload width in bits; legal range 4..247.
CNT_WIDTH, 16, width of each saturating error counter.
PARITY_WIDTH, derived localparam (not overridable): r+1, where r is the smallest value with 2^r >= DATA_WIDTH+r+1. DATA_WIDTH=75 gives 8.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
enc_valid  in  1  encode request
enc_data  in  DATA_WIDTH  payload to encode
enc_inj_en  in  1  enable error injection on this word
enc_inj_dbl  in  1  1: flip two bits; 0: flip one bit
enc_inj_pos0  in  8  first data bit index to flip
enc_inj_pos1  in  8  second data bit index to flip
enc_out_valid  out  1  encoded word valid
enc_out_data  out  DATA_WIDTH  payload, after any injection
enc_out_parity  out  PARITY_WIDTH  parity computed on the un-injected payload
dec_in_valid  in  1  decode request
dec_in_ready  out  1  decoder can accept a word
dec_in_data  in  DATA_WIDTH  stored payload
dec_in_parity  in  PARITY_WIDTH  stored parity
dec_out_valid  out  1  decoded word valid
dec_out_ready  in  1  downstream accepts
dec_out_data  out  DATA_WIDTH  corrected payload
dec_out_sbit  out  1  single-bit error, corrected
dec_out_dbit  out  1  uncorrectable error
dec_out_syndrome  out  PARITY_WIDTH  raw syndrome
bypass  in  1  disables correction and flags; static, change only while idle
cnt_clr  in  1  clear counters and error log
sbit_cnt  out  CNT_WIDTH  saturating single-error count
dbit_cnt  out  CNT_WIDTH  saturating double-error count
err_log_valid  out  1  sticky: an error has been logged
err_log_syndrome  out  PARITY_WIDTH  syndrome of the first error since clear

Behaviour:
Code construction:
- Data bit i maps to the i-th non-power-of-two Hamming position, counting from 3 (bit0->3, bit1->5, bit2->6, bit3->7, bit4->9, ...).
- p[k], k<r: XOR of data bits whose position has bit k set.
- p[r]: XOR of all data bits and p[r-1:0] (overall parity).

Encode path:
- Latency 1, no backpressure.
- enc_out_valid is the registered enc_valid.
- Injection XORs a one-hot at pos0, and also at pos1 when enc_inj_dbl=1.
- If pos0 or pos1 >= DATA_WIDTH, that flip is ignored.
- If pos0 == pos1 with dbl=1, the flips cancel: no error.

Decode path:
- Stage 1 registers data, parity and syndrome = in_parity ^ recomputed parity. Let S = syndrome[r-1:0] and O = syndrome[r].
- Stage 2 registers mask, corrected data and flags:
  - S=0, O=0: clean.
  - O=1, S=0: sbit; error in p[r]; data unchanged.
  - O=1, S is a power of two: sbit; error in a parity bit; data unchanged.
  - O=1, S maps to data bit i: sbit; flip bit i.
  - O=1, S > highest used position: dbit; data passed unchanged.
  - O=0, S!=0: dbit; data unchanged.
- Latency is 2 cycles when dec_out_ready=1. Throughput is 1 word/cycle.

Handshake:
- A stage advances when it is empty or the next stage advances.
- dec_in_ready = !s1_valid || s1_advance. It is combinational from dec_out_ready (no skid).
- While dec_out_valid=1 and dec_out_ready=0, all dec_out_* signals stay stable.

bypass=1:
- dec_out_data = dec_in_data unchanged.
- sbit=dbit=0 and counters are not updated.
- dec_out_syndrome is still reported.

Counters and error log:
- Counters increment by 1 on each output transfer (dec_out_valid & dec_out_ready) carrying the corresponding flag.
- Counters saturate at all-ones.
- err_log_syndrome captures the syndrome on the first flagged transfer; err_log_valid is then set and held.
- cnt_clr has priority over a same-cycle increment or capture: the result is 0 and invalid.

Reset (synchronous, active-high):
- Cleared to 0: enc_out_valid, enc_out_data, enc_out_parity, dec_out_valid, dec_out_data, dec_out_sbit, dec_out_dbit, dec_out_syndrome, sbit_cnt, dbit_cnt, err_log_valid, err_log_syndrome.
- dec_in_ready is 1 in the cycle after reset.
- Asserting reset mid-operation discards in-flight words; no partial output appears.

Test Plan:
- Round trip, DATA_WIDTH=75: encode 0 -> parity 8'h00. Decode data=0 and parity=0 -> clean output, syndrome 0, 2-cycle latency.
- Single flip: inject pos0=0 on data 0 -> decode gives syndrome 8'b1000_0011, sbit=1, corrected data 0, sbit_cnt=1. Stored parity bit 2 flipped -> syndrome 8'b1000_0100, sbit=1, data unchanged.
- Double flip: inject pos0=0, pos1=1, dbl=1 -> syndrome 8'b0000_0110, dbit=1, data passed through, dbit_cnt=1. err_log_syndrome=8'h06 if this is the first error.
- Backpressure: hold dec_out_ready=0 and send 3 words -> 2 accepted, dec_in_ready=0 on the 3rd, output held stable. Release -> 3 words out in order, no loss or duplication.
- Saturation/clear, CNT_WIDTH=4: 20 single-error words -> sbit_cnt=15. cnt_clr in the same cycle as an error transfer -> 0 and err_log_valid=0.
- Bypass=1 with a single-flip word -> data unchanged, flags 0, counters unchanged, syndrome 8'b1000_0011 reported. Reset while 2 words are in flight -> dec_out_valid=0 next cycle.
